// File: rtl/mux_scan_nx1.sv
// Registered N:1 mux with a round-robin auto-scan over masked channels; 1-cycle latency.
// No backpressure: en gates sampling, and every edge with en=1 and something selectable takes one sample.
module mux_scan_nx1 #(
    parameter int WIDTH = 4,
    parameter int SEL_W = 3
) (
    input  logic                          clock,
    input  logic                          reset_b,
    input  logic [(2**SEL_W)*WIDTH-1:0]   d,
    input  logic [SEL_W-1:0]              sel,
    input  logic                          mode,
    input  logic                          en,
    input  logic [(2**SEL_W)-1:0]         mask,
    output logic [WIDTH-1:0]              y,
    output logic [SEL_W-1:0]              ch,
    output logic                          valid,
    output logic                          wrap
);

    localparam int N = 2**SEL_W;

    logic [WIDTH-1:0] y_q, y_d;
    logic [SEL_W-1:0] ch_q, ch_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;

    logic [SEL_W-1:0] scan_s;
    logic [SEL_W-1:0] scan_nxt;
    logic [SEL_W-1:0] idx;
    logic             scan_hit;

    // Offsets are walked from largest to smallest so the nearest enabled
    // channel is the last one written and therefore wins.
    always_comb begin
        scan_hit = |mask;
        scan_s   = ptr_q;
        scan_nxt = ptr_q;
        idx      = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = ptr_q + SEL_W'(i);
            if (mask[idx]) begin
                scan_s = idx;
            end
        end
        // Offset N aliases to scan_s itself, so a lone enabled channel
        // points back at itself and reports a wrap.
        for (int i = N; i >= 1; i--) begin
            idx = scan_s + SEL_W'(i);
            if (mask[idx]) begin
                scan_nxt = idx;
            end
        end
    end

    always_comb begin
        y_d     = y_q;
        ch_d    = ch_q;
        ptr_d   = ptr_q;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        if (en) begin
            if (!mode) begin
                y_d     = d[sel*WIDTH +: WIDTH];
                ch_d    = sel;
                valid_d = 1'b1;
            end else if (scan_hit) begin
                y_d     = d[scan_s*WIDTH +: WIDTH];
                ch_d    = scan_s;
                ptr_d   = scan_nxt;
                valid_d = 1'b1;
                wrap_d  = (scan_nxt <= scan_s);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_b) begin
            y_q     <= '0;
            ch_q    <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            y_q     <= y_d;
            ch_q    <= ch_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign y     = y_q;
    assign ch    = ch_q;
    assign valid = valid_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Directed walk through the scanner's behaviours followed by randomized traffic,
// all compared against a cycle-level reference model.
module tb_mux_scan_nx1;

    localparam int WIDTH = 4;
    localparam int SEL_W = 3;
    localparam int N     = 8;

    logic                 clock = 1'b0;
    logic                 reset_b;
    logic [N*WIDTH-1:0]   d;
    logic [SEL_W-1:0]     sel;
    logic                 mode;
    logic                 en;
    logic [N-1:0]         mask;
    logic [WIDTH-1:0]     y;
    logic [SEL_W-1:0]     ch;
    logic                 valid;
    logic                 wrap;

    int checks = 0;
    int errors = 0;

    // Reference state
    int m_y, m_ch, m_ptr, m_valid, m_wrap;

    mux_scan_nx1 #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
        .clock   (clock),
        .reset_b (reset_b),
        .d       (d),
        .sel     (sel),
        .mode    (mode),
        .en      (en),
        .mask    (mask),
        .y       (y),
        .ch      (ch),
        .valid   (valid),
        .wrap    (wrap)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int chan_data(input int k);
        logic [N*WIDTH-1:0] dv;
        dv = d;
        return int'(dv[k*WIDTH +: WIDTH]);
    endfunction

    // Model one edge from the spec's rules using modular index arithmetic.
    task automatic model_step();
        int s, nx;
        if (!reset_b) begin
            m_y = 0; m_ch = 0; m_ptr = 0; m_valid = 0; m_wrap = 0;
        end else if (!en) begin
            m_valid = 0; m_wrap = 0;
        end else if (!mode) begin
            m_y = chan_data(int'(sel)); m_ch = int'(sel); m_valid = 1; m_wrap = 0;
        end else if (mask == '0) begin
            m_valid = 0; m_wrap = 0;
        end else begin
            s = -1;
            for (int i = 0; i < N; i++) begin
                if (s < 0 && mask[(m_ptr + i) % N]) s = (m_ptr + i) % N;
            end
            nx = -1;
            for (int i = 1; i <= N; i++) begin
                if (nx < 0 && mask[(s + i) % N]) nx = (s + i) % N;
            end
            m_y = chan_data(s); m_ch = s; m_ptr = nx; m_valid = 1;
            m_wrap = (nx <= s) ? 1 : 0;
        end
    endtask

    task automatic cyc(input logic rb, input logic e, input logic md,
                       input logic [SEL_W-1:0] s, input logic [N-1:0] mk, input string tag);
        reset_b = rb; en = e; mode = md; sel = s; mask = mk;
        @(posedge clock);
        model_step();
        #1;
        chk({tag, ".y"},     32'(y),     32'(m_y));
        chk({tag, ".ch"},    32'(ch),    32'(m_ch));
        chk({tag, ".valid"}, 32'(valid), 32'(m_valid));
        chk({tag, ".wrap"},  32'(wrap),  32'(m_wrap));
    endtask

    task automatic expect_out(input string tag, input int ey, input int ech, input int ev, input int ew);
        chk({tag, ".exp_y"},     32'(y),     32'(ey));
        chk({tag, ".exp_ch"},    32'(ch),    32'(ech));
        chk({tag, ".exp_valid"}, 32'(valid), 32'(ev));
        chk({tag, ".exp_wrap"},  32'(wrap),  32'(ew));
    endtask

    initial begin
        int sp_ch[5];
        int sp_y[5];
        int e7;
        logic [N-1:0] rmask;

        m_y = 0; m_ch = 0; m_ptr = 0; m_valid = 0; m_wrap = 0;
        for (int k = 0; k < N; k++) d[k*WIDTH +: WIDTH] = WIDTH'(15 - k);
        reset_b = 1'b0; en = 1'b1; mode = 1'b1; sel = '0; mask = 8'hFF;
        #2;

        // Reset held for two edges
        cyc(1'b0, 1'b1, 1'b1, 3'd0, 8'hFF, "rst0");
        cyc(1'b0, 1'b1, 1'b1, 3'd0, 8'hFF, "rst1");
        expect_out("rst", 0, 0, 0, 0);
        cyc(1'b1, 1'b1, 1'b1, 3'd0, 8'hFF, "rel");
        expect_out("rel", 15, 0, 1, 0);

        // Direct mode
        cyc(1'b1, 1'b1, 1'b0, 3'd5, 8'hFF, "dir5");
        expect_out("dir5", 4'hA, 5, 1, 0);
        cyc(1'b1, 1'b1, 1'b0, 3'd2, 8'hFF, "dir2");
        expect_out("dir2", 4'hD, 2, 1, 0);
        cyc(1'b1, 1'b0, 1'b0, 3'd6, 8'hFF, "dir_hold");
        expect_out("dir_hold", 4'hD, 2, 0, 0);

        // Full scan from a fresh pointer
        cyc(1'b0, 1'b1, 1'b1, 3'd0, 8'hFF, "rst_fs");
        for (int i = 0; i < 9; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 3'd0, 8'hFF, $sformatf("full%0d", i));
            expect_out($sformatf("full%0d", i), 15 - (i % 8), i % 8, 1, (i % 8 == 7) ? 1 : 0);
        end

        // Sparse mask, then single channel, then empty mask
        sp_ch = '{2, 5, 7, 2, 5};
        sp_y  = '{4'hD, 4'hA, 4'h8, 4'hD, 4'hA};
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 3'd0, 8'b1010_0100, $sformatf("sparse%0d", i));
            expect_out($sformatf("sparse%0d", i), sp_y[i], sp_ch[i], 1, (sp_ch[i] == 7) ? 1 : 0);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 3'd0, 8'b0001_0000, $sformatf("single%0d", i));
            expect_out($sformatf("single%0d", i), 4'hB, 4, 1, 1);
        end
        cyc(1'b1, 1'b1, 1'b1, 3'd0, 8'h00, "empty");
        expect_out("empty", 4'hB, 4, 0, 0);

        // Scan up to ch 3, detour through direct mode, resume at ch 4
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 3'd0, 8'hFF, $sformatf("pre%0d", i));
        end
        expect_out("pre_end", 4'hC, 3, 1, 0);
        cyc(1'b1, 1'b1, 1'b0, 3'd6, 8'hFF, "ilv_d0");
        cyc(1'b1, 1'b1, 1'b0, 3'd6, 8'hFF, "ilv_d1");
        expect_out("ilv_d1", 4'h9, 6, 1, 0);
        cyc(1'b1, 1'b1, 1'b1, 3'd0, 8'hFF, "ilv_back");
        expect_out("ilv_back", 4'hB, 4, 1, 0);

        // Reset mid-scan, then restart on an edited mask
        cyc(1'b1, 1'b1, 1'b1, 3'd0, 8'hFF, "ms5");
        cyc(1'b1, 1'b1, 1'b1, 3'd0, 8'hFF, "ms6");
        expect_out("ms6", 4'h9, 6, 1, 0);
        cyc(1'b0, 1'b1, 1'b1, 3'd0, 8'hFF, "ms_rst");
        expect_out("ms_rst", 0, 0, 0, 0);
        cyc(1'b1, 1'b1, 1'b1, 3'd0, 8'b1100_0000, "mr0");
        expect_out("mr0", 4'h9, 6, 1, 0);
        cyc(1'b1, 1'b1, 1'b1, 3'd0, 8'b1100_0000, "mr1");
        expect_out("mr1", 4'h8, 7, 1, 1);
        cyc(1'b1, 1'b1, 1'b1, 3'd0, 8'b1100_0000, "mr2");
        expect_out("mr2", 4'h9, 6, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            d = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0: rmask = 8'h00;
                1: rmask = 8'(1 << $urandom_range(0, 7));
                default: rmask = 8'($urandom);
            endcase
            e7 = $urandom_range(0, 9);
            cyc(($urandom_range(0, 24) != 0), (e7 < 8), ($urandom_range(0, 3) != 0),
                3'($urandom), rmask, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_scan_nx1.md
# mux_scan_nx1

Parametrised, registered N-to-1 multiplexer with a built-in channel scanner. It generalises the gate-level 8x1 mux used for function realisation to arbitrary channel count and data width. It adds a clocked output stage and an auto-scan mode that sweeps enabled channels round-robin. It sits between a bank of parallel sources and a single serial consumer, for example a display or a shared ALU input.

## Interface
Parameters:
- WIDTH, 4, data width of each channel
- SEL_W, 3, select width; channel count N = 2**SEL_W

Ports:
- clock  input  1  single system clock, rising-edge
- reset_b  input  1  synchronous, active-low reset; sampled on the rising edge of clock
- d  input  N*WIDTH  flattened channel data; channel k occupies d[k*WIDTH +: WIDTH]
- sel  input  SEL_W  channel select, used in direct mode only
- mode  input  1  0 = direct select, 1 = auto-scan
- en  input  1  sample/advance enable
- mask  input  N  scan enable per channel; bit k = 1 includes channel k; ignored in direct mode
- y  output  WIDTH  registered selected data
- ch  output  SEL_W  index of the channel currently held in y
- valid  output  1  one-cycle pulse: y/ch were loaded on the last edge
- wrap  output  1  one-cycle pulse: last sample closed a scan pass

## Operation
- Reset (reset_b = 0 at an edge): y = 0, ch = 0, valid = 0, wrap = 0, internal scan pointer ptr = 0. Reset overrides all other inputs.
- en = 0, any mode:
  - y, ch and ptr hold.
  - valid = 0, wrap = 0.
- Direct mode (mode = 0, en = 1):
  - y <= channel sel; ch <= sel; valid <= 1; wrap <= 0.
  - ptr holds.
- Scan mode (mode = 1, en = 1):
  - Sampled channel s = first index with mask[s] = 1, searching ascending from ptr with cyclic wrap past N-1 to 0.
  - y <= channel s; ch <= s; valid <= 1.
  - ptr <= next enabled index after s (cyclic).
  - wrap <= 1 iff that next index is <= s. A single enabled channel therefore wraps on every sample.
- Scan with mask = 0: no sample. y, ch and ptr hold; valid = 0, wrap = 0.
- Mask changes mid-pass take effect on the next sample. If ptr points at a newly masked channel, the search skips forward from it; no stale sample is taken.
- Mode switch:
  - 1 -> 0: ptr is preserved.
  - 0 -> 1: scanning resumes from the preserved ptr, not from 0.
- Selection logic is combinational; every output is a flop. There is no combinational path from d to y.

## Timing
- Latency is 1 cycle. Inputs sampled at edge t appear on y/ch/valid/wrap after edge t.
- Throughput is one sample per cycle while en = 1.
- valid and wrap are single-cycle pulses aligned with the y update. Both are 0 in the cycle after any edge with en = 0, mask = 0 (in scan mode), or reset.
- Release of reset_b: the first sample can occur at the first edge where reset_b = 1 and en = 1.
- Reset asserted mid-scan: ptr returns to 0, and the next scan starts at the lowest enabled channel.

## Test plan
Common setup: WIDTH = 4, SEL_W = 3; channel k data = 15-k (ch0 = 4'hF, ch7 = 4'h8).
- Reset: hold reset_b = 0 for 2 edges with en = 1, mode = 1 -> y = 0, ch = 0, valid = 0, wrap = 0. Then release with en = 1, mask = 8'hFF -> first sample y = 4'hF, ch = 0.
- Direct mode: mode = 0, en = 1, sel = 5 then sel = 2 -> y = 4'hA, ch = 5, then y = 4'hD, ch = 2; valid = 1 both cycles; wrap stays 0. Drop en -> y holds 4'hD, valid = 0.
- Full scan: mode = 1, mask = 8'hFF, en = 1 for 9 cycles -> ch = 0,1,...,7,0. wrap = 1 only with ch = 7; valid = 1 every cycle.
- Sparse mask: mask = 8'b1010_0100 -> ch = 2,5,7,2,5 and y = 4'hD,4'hA,4'h8,4'hD,4'hA; wrap = 1 with ch = 7. Next, mask = 8'b0001_0000 -> ch = 4 every sample with wrap = 1 every sample. Next, mask = 0 -> valid = 0, y holds 4'hB.
- Mode interleave: scan to ch = 3 (ptr = 4), switch to mode = 0 with sel = 6 for 2 cycles (y = 4'h9), return to mode = 1 -> next ch = 4, y = 4'hB.
- Mid-scan reset plus mask edit: reset_b = 0 while ch = 6 -> all outputs 0. After release with mask = 8'b1100_0000 -> ch = 6, 7 (wrap = 1), 6.
